flush_ctrl: RTL and testbench
=============================

// Module: flush_ctrl
// PURPOSE
//   Sequences pipeline flush/redirect. Compares EX-stage branch outcomes with the
//   fetch prediction, and on a mispredict or trap drives the flush and correction
//   PC that select npc_corr and pull down the stage resets. Holds flush for a
//   minimum squash window and until fetch accepts the redirect. Keeps a flush count.
// PARAMETERS
//   WordSize     32  PC / address width
//   FlushCycles  2   minimum cycles flush stays high per event (>=1)
//   CntWidth     16  width of flush event counter
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         synchronous reset, active-high
//   ex_valid     in   1         EX holds a valid instruction this cycle
//   ex_is_branch in   1         EX instruction is a branch/jump
//   ex_taken     in   1         resolved direction
//   ex_target    in   WordSize  resolved taken target
//   ex_pc        in   WordSize  PC of EX instruction
//   ex_pred_npc  in   WordSize  next PC fetch predicted for this instruction
//   trap_req     in   1         synchronous trap/exception request
//   trap_vec     in   WordSize  trap handler address
//   fetch_ready  in   1         fetch accepts npc_corr this cycle
//   flush        out  1         squash younger stages, select npc_corr
//   npc_corr     out  WordSize  correction PC, stable while flush=1
//   stall_ex     out  1         hold EX/MEM issue while redirect in progress
//   busy         out  1         FSM not in IDLE
//   flush_count  out  CntWidth  flush events accepted since reset
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=IDLE, flush=0, npc_corr=0, stall_ex=0,
//     busy=0, flush_count=0, cnt=0. Reset overrides all inputs that cycle.
//   Actual next PC: act = ex_taken ? ex_target : ex_pc + 4 (mod 2^WordSize).
//   mispredict = ex_valid & ex_is_branch & (act != ex_pred_npc).
//   Non-branch or correctly predicted instructions never cause a flush.
//   Event = trap_req | mispredict; trap has priority (npc_corr = trap_vec).
//   All outputs registered; flush rises 1 cycle after the event cycle.
//   FSM:
//     IDLE:  on event -> FLUSH; latch npc_corr (trap_vec or act);
//            cnt = FlushCycles-1; flush_count += 1 (saturate at all-ones).
//     FLUSH: flush=1, stall_ex=1, busy=1. cnt decrements to 0 (holds at 0).
//            Leave to IDLE when cnt==0 & fetch_ready (that cycle is last flush=1).
//            mispredict while in FLUSH ignored (squashed younger instr).
//            trap_req in FLUSH: npc_corr <= trap_vec, cnt reloads FlushCycles-1,
//            flush_count += 1, stay in FLUSH.
//     No third state; fetch_ready low with cnt==0 holds FLUSH, npc_corr stable.
//   Event in the same cycle FLUSH exits (cnt==0 & fetch_ready): trap re-enters
//     FLUSH per FLUSH rule; mispredict ignored.
//   Minimum flush width = FlushCycles cycles; back-to-back events from IDLE
//     (event on cycle after exit) re-enter FLUSH with no gap requirement.
//   flush_count saturates; never wraps.
//   rst mid-FLUSH: next cycle all outputs at reset values, event discarded.
// TESTING
//   1 ex_pc=0x100, taken, target=0x200, pred=0x200 -> flush stays 0, count=0.
//   2 ex_pc=0x100, not taken, pred=0x200, fetch_ready=1 -> flush=1 for exactly
//     2 cycles starting cycle+1, npc_corr=0x104, flush_count=1.
//   3 Mispredict target 0x300 with fetch_ready=0 for 5 cycles -> flush held 6
//     cycles, npc_corr=0x300 stable throughout, exits on fetch_ready.
//   4 Mispredict + trap_req (trap_vec=0x80) same cycle -> npc_corr=0x80, count=1;
//     trap during FLUSH with vec 0x90 -> npc_corr=0x90, window restarts, count=2.
//   5 rst asserted during 2nd flush cycle -> next cycle flush=0, npc_corr=0,
//     flush_count=0, busy=0.
//   6 ex_pc=0xFFFFFFFC not taken, pred=0 -> no flush (wrap to 0); CntWidth=2
//     with 5 events -> flush_count sticks at 3.

Source files
------------

// File: rtl/flush_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : flush_ctrl_if
//  Brief    : EX-stage outcome / fetch redirect bundle between the pipeline
//             and the flush controller.
//  Revision : 1.0  initial release
// ============================================================================
interface flush_ctrl_if #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 ex_valid;
    logic                 ex_is_branch;
    logic                 ex_taken;
    logic [WORD_SIZE-1:0] ex_target;
    logic [WORD_SIZE-1:0] ex_pc;
    logic [WORD_SIZE-1:0] ex_pred_npc;
    logic                 trap_req;
    logic [WORD_SIZE-1:0] trap_vec;
    logic                 fetch_ready;
    logic                 flush;
    logic [WORD_SIZE-1:0] npc_corr;
    logic                 stall_ex;
    logic                 busy;
    logic [CNT_WIDTH-1:0] flush_count;

    // Pipeline side: supplies EX outcomes and fetch acceptance.
    modport master (
        output ex_valid, ex_is_branch, ex_taken, ex_target, ex_pc, ex_pred_npc,
        output trap_req, trap_vec, fetch_ready,
        input  flush, npc_corr, stall_ex, busy, flush_count
    );

    // Flush controller side.
    modport slave (
        input  ex_valid, ex_is_branch, ex_taken, ex_target, ex_pc, ex_pred_npc,
        input  trap_req, trap_vec, fetch_ready,
        output flush, npc_corr, stall_ex, busy, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flush_ctrl
//  Brief    : Detects branch mispredicts and traps at EX, then holds a flush
//             with a correction PC for a minimum squash window and until
//             fetch accepts the redirect. Counts accepted flush events.
//  Revision : 1.0  initial release
// ============================================================================
module flush_ctrl #(
    parameter int WORD_SIZE    = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    flush_ctrl_if.slave     bus
);
    // Window counter only needs to hold FLUSH_CYCLES-1.
    localparam int c_cnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [WORD_SIZE-1:0] r_npc_corr;
    logic [WORD_SIZE-1:0] w_npc_corr_nxt;
    logic [CNT_WIDTH-1:0] r_flush_count;
    logic [CNT_WIDTH-1:0] w_flush_count_nxt;
    logic [CNT_WIDTH-1:0] w_flush_count_inc;
    logic [WORD_SIZE-1:0] w_act_npc;
    logic                 w_mispredict;

    // Resolved next PC; the +4 wraps naturally at the top of the address space.
    assign w_act_npc    = bus.ex_taken ? bus.ex_target : (bus.ex_pc + WORD_SIZE'(4));
    assign w_mispredict = bus.ex_valid & bus.ex_is_branch & (w_act_npc != bus.ex_pred_npc);

    // Event counter sticks at all-ones instead of wrapping.
    assign w_flush_count_inc = (&r_flush_count) ? r_flush_count
                                                : (r_flush_count + CNT_WIDTH'(1));

    // State register and latched redirect information.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_npc_corr    <= '0;
            r_flush_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_npc_corr    <= w_npc_corr_nxt;
            r_flush_count <= w_flush_count_nxt;
        end
    end

    // Next-state: traps win over mispredicts; mispredicts are squashed while flushing.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_npc_corr_nxt    = r_npc_corr;
        w_flush_count_nxt = r_flush_count;
        case (r_state)
            ST_IDLE: begin
                if (bus.trap_req) begin
                    w_state_nxt       = ST_FLUSH;
                    w_npc_corr_nxt    = bus.trap_vec;
                    w_cnt_nxt         = c_cnt_reload;
                    w_flush_count_nxt = w_flush_count_inc;
                end else if (w_mispredict) begin
                    w_state_nxt       = ST_FLUSH;
                    w_npc_corr_nxt    = w_act_npc;
                    w_cnt_nxt         = c_cnt_reload;
                    w_flush_count_nxt = w_flush_count_inc;
                end
            end
            ST_FLUSH: begin
                if (bus.trap_req) begin
                    // A trap restarts the squash window with the new vector.
                    w_npc_corr_nxt    = bus.trap_vec;
                    w_cnt_nxt         = c_cnt_reload;
                    w_flush_count_nxt = w_flush_count_inc;
                end else if ((r_cnt == '0) && bus.fetch_ready) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // All outputs come straight from registers.
    assign bus.flush       = (r_state == ST_FLUSH);
    assign bus.stall_ex    = (r_state == ST_FLUSH);
    assign bus.busy        = (r_state == ST_FLUSH);
    assign bus.npc_corr    = r_npc_corr;
    assign bus.flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flush_ctrl
//  Brief    : Bench for flush_ctrl: directed scenarios plus random traffic
//             against a cycle-level reference model. Two instances differ
//             only in counter width so saturation is observable.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flush_ctrl;
    localparam int WS = 32;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_is_branch, ex_taken;
    logic [WS-1:0] ex_target, ex_pc, ex_pred_npc, trap_vec;
    logic          trap_req, fetch_ready;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state: in-flush flag, flush cycles still owed, target, event total.
    bit            m_in_flush = 1'b0;
    int            m_left     = 0;
    logic [WS-1:0] m_target   = '0;
    longint        m_events   = 0;

    flush_ctrl_if #(.WORD_SIZE(WS), .CNT_WIDTH(16)) bus_a ();
    flush_ctrl_if #(.WORD_SIZE(WS), .CNT_WIDTH(2))  bus_b ();

    flush_ctrl #(.WORD_SIZE(WS), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave));
    flush_ctrl #(.WORD_SIZE(WS), .FLUSH_CYCLES(FC), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave));

    assign bus_a.ex_valid = ex_valid;       assign bus_b.ex_valid = ex_valid;
    assign bus_a.ex_is_branch = ex_is_branch; assign bus_b.ex_is_branch = ex_is_branch;
    assign bus_a.ex_taken = ex_taken;       assign bus_b.ex_taken = ex_taken;
    assign bus_a.ex_target = ex_target;     assign bus_b.ex_target = ex_target;
    assign bus_a.ex_pc = ex_pc;             assign bus_b.ex_pc = ex_pc;
    assign bus_a.ex_pred_npc = ex_pred_npc; assign bus_b.ex_pred_npc = ex_pred_npc;
    assign bus_a.trap_req = trap_req;       assign bus_b.trap_req = trap_req;
    assign bus_a.trap_vec = trap_vec;       assign bus_b.trap_vec = trap_vec;
    assign bus_a.fetch_ready = fetch_ready; assign bus_b.fetch_ready = fetch_ready;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: applies the redirect rules to the inputs seen at this edge.
    always @(posedge clk) begin
        logic [WS-1:0] act;
        bit            mis;
        act = ex_taken ? ex_target : ex_pc + 32'd4;
        mis = ex_valid && ex_is_branch && (act != ex_pred_npc);
        if (rst) begin
            m_in_flush = 1'b0; m_left = 0; m_target = '0; m_events = 0;
        end else if (!m_in_flush) begin
            if (trap_req || mis) begin
                m_in_flush = 1'b1;
                m_left     = FC;
                m_target   = trap_req ? trap_vec : act;
                m_events   = m_events + 1;
            end
        end else begin
            // One flush cycle just completed.
            if (trap_req) begin
                m_target = trap_vec; m_left = FC; m_events = m_events + 1;
            end else if (m_left <= 1 && fetch_ready) begin
                m_in_flush = 1'b0; m_left = 0;
            end else if (m_left > 1) begin
                m_left = m_left - 1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("flush_a",    32'(bus_a.flush),    32'(m_in_flush));
            chk("stall_a",    32'(bus_a.stall_ex), 32'(m_in_flush));
            chk("busy_a",     32'(bus_a.busy),     32'(m_in_flush));
            chk("npc_a",      bus_a.npc_corr,      m_target);
            chk("count_a",    32'(bus_a.flush_count), 32'((m_events > 65535) ? 65535 : m_events));
            chk("flush_b",    32'(bus_b.flush),    32'(m_in_flush));
            chk("npc_b",      bus_b.npc_corr,      m_target);
            chk("count_b",    32'(bus_b.flush_count), 32'((m_events > 3) ? 3 : m_events));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_is_branch = 0; ex_taken = 0;
        ex_target = '0; ex_pc = '0; ex_pred_npc = '0;
        trap_req = 0; trap_vec = '0;
    endtask

    task automatic drive_br(input logic [WS-1:0] pc, input logic tk,
                            input logic [WS-1:0] tgt, input logic [WS-1:0] pred);
        ex_valid = 1; ex_is_branch = 1; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_pred_npc = pred;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        rst = 1; fetch_ready = 1; idle_inputs();
        step();
        chk_en = 1'b1;
        step();
        // Reset state
        chk("rst_flush", 32'(bus_a.flush), 32'd0);
        chk("rst_count", 32'(bus_a.flush_count), 32'd0);
        rst = 0;

        // 1: correctly predicted taken branch
        drive_br(32'h100, 1, 32'h200, 32'h200); step(); idle_inputs(); step();
        chk("t1_flush", 32'(bus_a.flush), 32'd0);
        chk("t1_count", 32'(bus_a.flush_count), 32'd0);

        // 2: not-taken mispredict, two-cycle flush
        drive_br(32'h100, 0, 32'h200, 32'h200); step(); idle_inputs();
        chk("t2_flush_c1", 32'(bus_a.flush), 32'd1);
        chk("t2_npc", bus_a.npc_corr, 32'h104);
        step();
        chk("t2_flush_c2", 32'(bus_a.flush), 32'd1);
        step();
        chk("t2_flush_end", 32'(bus_a.flush), 32'd0);
        chk("t2_count", 32'(bus_a.flush_count), 32'd1);

        // 3: fetch not ready for 5 flush cycles -> 6-cycle flush
        fetch_ready = 0;
        drive_br(32'h100, 1, 32'h300, 32'h104); step(); idle_inputs();
        for (int i = 0; i < 6; i++) begin
            chk("t3_flush_held", 32'(bus_a.flush), 32'd1);
            chk("t3_npc", bus_a.npc_corr, 32'h300);
            if (i == 5) fetch_ready = 1;
            step();
        end
        chk("t3_flush_end", 32'(bus_a.flush), 32'd0);

        // 4: trap beats mispredict, then trap restarts the window
        do_reset();
        drive_br(32'h100, 0, 32'h0, 32'h200); trap_req = 1; trap_vec = 32'h80;
        step(); idle_inputs();
        chk("t4_npc_trap", bus_a.npc_corr, 32'h80);
        chk("t4_count1", 32'(bus_a.flush_count), 32'd1);
        step();
        trap_req = 1; trap_vec = 32'h90;
        step(); idle_inputs();
        chk("t4_npc_retrap", bus_a.npc_corr, 32'h90);
        chk("t4_count2", 32'(bus_a.flush_count), 32'd2);
        chk("t4_flush_r1", 32'(bus_a.flush), 32'd1);
        step();
        chk("t4_flush_r2", 32'(bus_a.flush), 32'd1);
        step();
        chk("t4_flush_end", 32'(bus_a.flush), 32'd0);

        // 5: reset during second flush cycle
        drive_br(32'h100, 0, 32'h0, 32'h200); step(); idle_inputs(); step();
        rst = 1; step(); rst = 0;
        chk("t5_flush", 32'(bus_a.flush), 32'd0);
        chk("t5_npc", bus_a.npc_corr, 32'd0);
        chk("t5_count", 32'(bus_a.flush_count), 32'd0);
        chk("t5_busy", 32'(bus_a.busy), 32'd0);

        // 6: PC wrap is a correct prediction; narrow counter saturates
        drive_br(32'hFFFF_FFFC, 0, 32'h0, 32'h0); step(); idle_inputs(); step();
        chk("t6_wrap_flush", 32'(bus_a.flush), 32'd0);
        for (int e = 0; e < 5; e++) begin
            drive_br(32'h400, 0, 32'h0, 32'h800); step(); idle_inputs(); step(); step();
        end
        chk("t6_count_a", 32'(bus_a.flush_count), 32'd5);
        chk("t6_count_b", 32'(bus_b.flush_count), 32'd3);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [WS-1:0] pc, act;
            rst          = ($urandom_range(0, 299) == 0);
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_is_branch = ($urandom_range(0, 2) != 0);
            ex_taken     = $urandom_range(0, 1);
            pc           = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC
                                                        : 32'($urandom_range(0, 255) * 4);
            ex_pc        = pc;
            ex_target    = 32'($urandom_range(0, 255) * 4);
            act          = ex_taken ? ex_target : pc + 32'd4;
            ex_pred_npc  = ($urandom_range(0, 1) != 0) ? act : 32'($urandom_range(0, 255) * 4);
            trap_req     = ($urandom_range(0, 15) == 0);
            trap_vec     = 32'($urandom_range(0, 63) * 16);
            fetch_ready  = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 0; idle_inputs(); fetch_ready = 1;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
